// File: rtl/exponent_controller_if.sv
// ---------------------------------------------------------------------------
// exponent_controller_if
//   Avalon-MM slave bus between the host interconnect and the exponent
//   controller register file, plus the level interrupt back to the host.
//
//   address   : word register index (3 bits)
//   write     : write strobe, writedata valid with it
//   writedata : write data
//   read      : read strobe, readdata valid on the following cycle
//   readdata  : registered read data
//   irq       : level interrupt towards the host
// ---------------------------------------------------------------------------
interface exponent_controller_if #(
  parameter int DATA_W = 32
);
  logic [2:0]        address;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              read;
  logic [DATA_W-1:0] readdata;
  logic              irq;

  modport master (
    output address, write, writedata, read,
    input  readdata, irq
  );

  modport slave (
    input  address, write, writedata, read,
    output readdata, irq
  );
endinterface

// File: rtl/exponent_controller.sv
// ---------------------------------------------------------------------------
// exponent_controller
//   Register front-end that sequences one iterative exponent core
//   (result = base^exp) on behalf of the host. The host loads BASE/EXP and
//   writes START; the controller handshakes with the core, captures the
//   result and the operation length in cycles, and raises an interrupt.
//
//   clock      : system clock
//   reset      : synchronous, active-high reset
//   bus        : Avalon-MM slave (address/write/writedata/read/readdata/irq)
//   core_start : one-cycle start pulse to the core
//   core_x     : base operand, driven continuously from BASE
//   core_a     : exponent operand, driven continuously from EXP
//   core_p     : core result
//   core_ready : core idle / result-valid flag
//
//   Register map: 0 CTRL, 1 STATUS, 2 BASE, 3 EXP, 4 RESULT, 5 CYCLES,
//   6-7 read as zero.
// ---------------------------------------------------------------------------
module exponent_controller #(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 clock,
  input  logic                 reset,
  exponent_controller_if.slave bus,
  output logic                 core_start,
  output logic [DATA_W-1:0]    core_x,
  output logic [DATA_W-1:0]    core_a,
  input  logic [DATA_W-1:0]    core_p,
  input  logic                 core_ready
);

  localparam logic [DATA_W-1:0] ONE_W       = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] TIMEOUT_LIM = DATA_W'(TIMEOUT_CYCLES);
  localparam bit                TIMEOUT_EN  = (TIMEOUT_CYCLES != 32'sd0);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_LOW  = 3'd2,
    ST_WAIT_HIGH = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  state_t            state_r;
  state_t            state_s;

  logic [DATA_W-1:0] base_r;
  logic [DATA_W-1:0] exp_r;
  logic [DATA_W-1:0] result_r;
  logic [DATA_W-1:0] cycles_r;
  logic [DATA_W-1:0] count_r;
  logic [DATA_W-1:0] readdata_r;
  logic              irq_en_r;
  logic              done_r;
  logic              timeout_r;
  logic              irq_r;
  logic              core_start_r;

  logic              busy_s;
  logic              wr_ctrl_s;
  logic              start_req_s;
  logic              clear_req_s;
  logic              wr_base_s;
  logic              wr_exp_s;
  logic [DATA_W-1:0] cnt_inc_s;
  logic              timeout_hit_s;
  logic              start_accept_s;
  logic              issue_s;
  logic              capture_s;
  logic              abort_s;
  logic              finish_s;
  logic              count_en_s;
  logic [DATA_W-1:0] rd_mux_s;

  // BUSY is simply "an operation is in flight", so it cannot drift from the FSM.
  assign busy_s      = (state_r != ST_IDLE);
  assign wr_ctrl_s   = bus.write && (bus.address == 3'd0);
  assign start_req_s = wr_ctrl_s && bus.writedata[0];
  assign clear_req_s = wr_ctrl_s && bus.writedata[1];
  // Operands are frozen while busy so the core sees stable inputs.
  assign wr_base_s   = bus.write && (bus.address == 3'd2) && !busy_s;
  assign wr_exp_s    = bus.write && (bus.address == 3'd3) && !busy_s;

  // Saturating counter increment and timeout detection on the incremented value,
  // so an operation that would last TIMEOUT_CYCLES cycles is aborted instead.
  always_comb begin
    if (count_r == {DATA_W{1'b1}}) begin
      cnt_inc_s = count_r;
    end else begin
      cnt_inc_s = count_r + ONE_W;
    end
    timeout_hit_s = TIMEOUT_EN && (cnt_inc_s >= TIMEOUT_LIM);
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state and per-cycle control strobes.
  always_comb begin
    state_s        = state_r;
    start_accept_s = 1'b0;
    issue_s        = 1'b0;
    capture_s      = 1'b0;
    abort_s        = 1'b0;
    finish_s       = 1'b0;
    count_en_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_req_s) begin
          start_accept_s = 1'b1;
          state_s        = ST_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        count_en_s = 1'b1;
        if (timeout_hit_s) begin
          abort_s = 1'b1;
          state_s = ST_IDLE;
        end else if (core_ready) begin
          issue_s = 1'b1;
          state_s = ST_WAIT_LOW;
        end else begin
          state_s = ST_ISSUE;
        end
      end
      ST_WAIT_LOW: begin
        count_en_s = 1'b1;
        if (timeout_hit_s) begin
          abort_s = 1'b1;
          state_s = ST_IDLE;
        end else if (!core_ready) begin
          state_s = ST_WAIT_HIGH;
        end else begin
          state_s = ST_WAIT_LOW;
        end
      end
      ST_WAIT_HIGH: begin
        count_en_s = 1'b1;
        if (timeout_hit_s) begin
          abort_s = 1'b1;
          state_s = ST_IDLE;
        end else if (core_ready) begin
          capture_s = 1'b1;
          state_s   = ST_DONE;
        end else begin
          state_s = ST_WAIT_HIGH;
        end
      end
      ST_DONE: begin
        finish_s = 1'b1;
        state_s  = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Host-writable registers: operands and interrupt enable.
  always_ff @(posedge clock) begin
    if (reset) begin
      base_r   <= '0;
      exp_r    <= '0;
      irq_en_r <= 1'b0;
    end else begin
      if (wr_base_s) begin
        base_r <= bus.writedata;
      end
      if (wr_exp_s) begin
        exp_r <= bus.writedata;
      end
      if (wr_ctrl_s) begin
        irq_en_r <= bus.writedata[2];
      end
    end
  end

  // DONE/TIMEOUT flags; later statements win, so a clear never masks a completion.
  always_ff @(posedge clock) begin
    if (reset) begin
      done_r    <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      if (clear_req_s || start_accept_s) begin
        done_r    <= 1'b0;
        timeout_r <= 1'b0;
      end
      if (finish_s) begin
        done_r <= 1'b1;
      end
      if (abort_s) begin
        done_r    <= 1'b1;
        timeout_r <= 1'b1;
      end
    end
  end

  // Operation cycle counter plus RESULT/CYCLES capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_r  <= '0;
      result_r <= '0;
      cycles_r <= '0;
    end else begin
      if (start_accept_s) begin
        count_r <= '0;
      end else if (count_en_s) begin
        count_r <= cnt_inc_s;
      end
      if (capture_s) begin
        result_r <= core_p;
        cycles_r <= cnt_inc_s;
      end else if (abort_s) begin
        result_r <= '0;
        cycles_r <= cnt_inc_s;
      end
    end
  end

  // Registered core start pulse and level interrupt.
  always_ff @(posedge clock) begin
    if (reset) begin
      core_start_r <= 1'b0;
      irq_r        <= 1'b0;
    end else begin
      core_start_r <= issue_s;
      irq_r        <= done_r && irq_en_r;
    end
  end

  // Read-data selection; unmapped addresses and unused bits read as zero.
  always_comb begin
    rd_mux_s = '0;
    case (bus.address)
      3'd0:    rd_mux_s[2]   = irq_en_r;
      3'd1:    rd_mux_s[2:0] = {timeout_r, done_r, busy_s};
      3'd2:    rd_mux_s      = base_r;
      3'd3:    rd_mux_s      = exp_r;
      3'd4:    rd_mux_s      = result_r;
      3'd5:    rd_mux_s      = cycles_r;
      default: rd_mux_s      = '0;
    endcase
  end

  // readdata only moves on a read strobe and holds otherwise.
  always_ff @(posedge clock) begin
    if (reset) begin
      readdata_r <= '0;
    end else if (bus.read) begin
      readdata_r <= rd_mux_s;
    end
  end

  assign bus.readdata = readdata_r;
  assign bus.irq      = irq_r;
  assign core_start   = core_start_r;
  assign core_x       = base_r;
  assign core_a       = exp_r;

endmodule

// File: tb/tb_exponent_controller.sv
// ---------------------------------------------------------------------------
// tb_exponent_controller
//   Self-checking bench for exponent_controller with a behavioural core.
//   Inputs are driven on the falling edge and outputs sampled there too.
//   Core model: ready drops the cycle after start, result appears after
//   exp+2 cycles. With the controller FSM this gives an operation length of
//   exp+5 cycles (ISSUE 1, WAIT_LOW 2, WAIT_HIGH exp+2 including capture).
// ---------------------------------------------------------------------------
module tb_exponent_controller;

  localparam int DW = 32;

  logic          clock;
  logic          reset;
  logic          core_start;
  logic [DW-1:0] core_x;
  logic [DW-1:0] core_a;
  logic [DW-1:0] core_p;
  logic          core_ready;

  exponent_controller_if #(.DATA_W(DW)) bif ();

  exponent_controller #(.DATA_W(DW), .TIMEOUT_CYCLES(20)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bif.slave),
    .core_start (core_start),
    .core_x     (core_x),
    .core_a     (core_a),
    .core_p     (core_p),
    .core_ready (core_ready)
  );

  int          vectors;
  int          miscompares;
  int          starts;
  logic [31:0] sb_q[$];

  // Behavioural core controls.
  logic        hang;
  logic        model_rst;
  logic [31:0] rem;
  logic [31:0] pw;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] ipow(input logic [31:0] b, input logic [31:0] e);
    logic [31:0] r;
    r = 32'd1;
    for (logic [31:0] i = 32'd0; i < e; i++) r = r * b;
    return r;
  endfunction

  // Behavioural exponent core.
  always @(posedge clock) begin
    if (model_rst) begin
      core_ready <= 1'b1;
      core_p     <= 32'd0;
      rem        <= 32'd0;
      pw         <= 32'd0;
    end else if (core_start === 1'b1) begin
      core_ready <= 1'b0;
      rem        <= core_a + 32'd2;
      pw         <= ipow(core_x, core_a);
    end else if (!core_ready && !hang) begin
      if (rem == 32'd1) begin
        core_ready <= 1'b1;
        core_p     <= pw;
      end else begin
        rem <= rem - 32'd1;
      end
    end
  end

  // Counts core_start pulses for the exactly-one-pulse checks.
  always @(posedge clock) begin
    if (core_start === 1'b1) starts <= starts + 1;
  end

  // Bus tasks assume they are entered on a falling edge and leave on one.
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    bif.address   = a;
    bif.writedata = d;
    bif.write     = 1'b1;
    @(negedge clock);
    bif.write     = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    bif.address = a;
    bif.read    = 1'b1;
    @(negedge clock);
    bif.read    = 1'b0;
    d           = bif.readdata;
  endtask

  task automatic wait_done(output bit ok);
    logic [31:0] d;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      bus_read(3'd1, d);
      if (d[1]) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic [31:0] want;
    reset     = 1'b1;
    model_rst = 1'b1;
    repeat (3) @(negedge clock);
    reset     = 1'b0;
    model_rst = 1'b0;
    vectors++;
    if (bif.irq !== 1'b0 || core_start !== 1'b0 || bif.readdata !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_outs irq=%b start=%b rd=%h required 0 0 0", bif.irq, core_start, bif.readdata);
    end
    for (int a = 0; a < 8; a++) begin
      sb_q.push_back(32'd0);
      bus_read(a[2:0], rd);
      want = sb_q.pop_front();
      vectors++;
      if (rd !== want) begin
        miscompares++;
        $display("FAIL reset_read addr=%0d got=%h required=%h", a, rd, want);
      end
    end
  endtask

  task automatic test_basic();
    logic [31:0] rd;
    logic [31:0] want;
    logic [2:0]  addrs [4];
    bit          ok;
    int          s0;
    s0 = starts;
    addrs = '{3'd1, 3'd4, 3'd5, 3'd0};
    bus_write(3'd2, 32'd3);
    bus_write(3'd3, 32'd4);
    bus_write(3'd0, 32'h5);
    sb_q.push_back(32'h1);
    bus_read(3'd1, rd);
    want = sb_q.pop_front();
    vectors++;
    if (rd !== want) begin
      miscompares++;
      $display("FAIL basic_busy got=%h required=%h", rd, want);
    end
    wait_done(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL basic_done_wait got=timeout required=done");
    end
    sb_q.push_back(32'h2);
    sb_q.push_back(32'd81);
    sb_q.push_back(32'd9);
    sb_q.push_back(32'h4);
    for (int i = 0; i < 4; i++) begin
      bus_read(addrs[i], rd);
      want = sb_q.pop_front();
      vectors++;
      if (rd !== want) begin
        miscompares++;
        $display("FAIL basic_read addr=%0d got=%0d required=%0d", addrs[i], rd, want);
      end
    end
    vectors++;
    if (bif.irq !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_irq got=%b required=1", bif.irq);
    end
    vectors++;
    if (starts - s0 != 1) begin
      miscompares++;
      $display("FAIL basic_pulses got=%0d required=1", starts - s0);
    end
  endtask

  task automatic test_clear_and_zero_exp();
    logic [31:0] rd;
    logic [31:0] want;
    bit          ok;
    bus_write(3'd0, 32'h2);
    vectors++;
    if (bif.irq !== 1'b1) begin
      miscompares++;
      $display("FAIL clear_irq_lag got=%b required=1", bif.irq);
    end
    @(negedge clock);
    vectors++;
    if (bif.irq !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_irq got=%b required=0", bif.irq);
    end
    sb_q.push_back(32'h0);
    bus_read(3'd1, rd);
    want = sb_q.pop_front();
    vectors++;
    if (rd !== want) begin
      miscompares++;
      $display("FAIL clear_status got=%h required=%h", rd, want);
    end
    bus_write(3'd2, 32'd7);
    bus_write(3'd3, 32'd0);
    bus_write(3'd0, 32'h1);
    wait_done(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL zexp_done_wait got=timeout required=done");
    end
    sb_q.push_back(32'd1);
    bus_read(3'd4, rd);
    want = sb_q.pop_front();
    vectors++;
    if (rd !== want) begin
      miscompares++;
      $display("FAIL zexp_result got=%0d required=%0d", rd, want);
    end
    sb_q.push_back(32'd5);
    bus_read(3'd5, rd);
    want = sb_q.pop_front();
    vectors++;
    if (rd !== want) begin
      miscompares++;
      $display("FAIL zexp_cycles got=%0d required=%0d", rd, want);
    end
  endtask

  task automatic test_busy_writes();
    logic [31:0] rd;
    logic [31:0] want;
    bit          ok;
    int          s0;
    s0 = starts;
    bus_write(3'd2, 32'd2);
    bus_write(3'd3, 32'd10);
    bus_write(3'd0, 32'h3);
    sb_q.push_back(32'h1);
    bus_read(3'd1, rd);
    want = sb_q.pop_front();
    vectors++;
    if (rd !== want) begin
      miscompares++;
      $display("FAIL clrstart_status got=%h required=%h", rd, want);
    end
    bus_write(3'd2, 32'd5);
    bus_write(3'd3, 32'd7);
    bus_write(3'd0, 32'h1);
    sb_q.push_back(32'd2);
    bus_read(3'd2, rd);
    want = sb_q.pop_front();
    vectors++;
    if (rd !== want) begin
      miscompares++;
      $display("FAIL busy_base got=%0d required=%0d", rd, want);
    end
    sb_q.push_back(32'd10);
    bus_read(3'd3, rd);
    want = sb_q.pop_front();
    vectors++;
    if (rd !== want) begin
      miscompares++;
      $display("FAIL busy_exp got=%0d required=%0d", rd, want);
    end
    wait_done(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL busy_done_wait got=timeout required=done");
    end
    sb_q.push_back(32'd1024);
    bus_read(3'd4, rd);
    want = sb_q.pop_front();
    vectors++;
    if (rd !== want) begin
      miscompares++;
      $display("FAIL busy_result got=%0d required=%0d", rd, want);
    end
    sb_q.push_back(32'd15);
    bus_read(3'd5, rd);
    want = sb_q.pop_front();
    vectors++;
    if (rd !== want) begin
      miscompares++;
      $display("FAIL busy_cycles got=%0d required=%0d", rd, want);
    end
    vectors++;
    if (starts - s0 != 1) begin
      miscompares++;
      $display("FAIL busy_pulses got=%0d required=1", starts - s0);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] rd;
    logic [31:0] want;
    hang = 1'b1;
    bus_write(3'd2, 32'd2);
    bus_write(3'd3, 32'd3);
    bus_write(3'd0, 32'h1);
    // START sampled at edge E0; abort happens at edge E20 (count reaches 20).
    repeat (18) @(negedge clock);
    sb_q.push_back(32'h1);
    sb_q.push_back(32'h1);
    sb_q.push_back(32'h6);
    for (int i = 0; i < 3; i++) begin
      bus_read(3'd1, rd);
      want = sb_q.pop_front();
      vectors++;
      if (rd !== want) begin
        miscompares++;
        $display("FAIL timeout_status step=%0d got=%h required=%h", i, rd, want);
      end
    end
    sb_q.push_back(32'd0);
    bus_read(3'd4, rd);
    want = sb_q.pop_front();
    vectors++;
    if (rd !== want) begin
      miscompares++;
      $display("FAIL timeout_result got=%0d required=%0d", rd, want);
    end
    hang      = 1'b0;
    model_rst = 1'b1;
    @(negedge clock);
    model_rst = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    logic [31:0] want;
    bit          ok;
    bus_write(3'd2, 32'd3);
    bus_write(3'd3, 32'd6);
    bus_write(3'd0, 32'h5);
    repeat (4) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    vectors++;
    if (bif.irq !== 1'b0 || core_start !== 1'b0 || bif.readdata !== 32'd0) begin
      miscompares++;
      $display("FAIL midrst_outs irq=%b start=%b rd=%h required 0 0 0", bif.irq, core_start, bif.readdata);
    end
    for (int a = 0; a < 8; a++) begin
      sb_q.push_back(32'd0);
      bus_read(a[2:0], rd);
      want = sb_q.pop_front();
      vectors++;
      if (rd !== want) begin
        miscompares++;
        $display("FAIL midrst_read addr=%0d got=%h required=%h", a, rd, want);
      end
    end
    bus_write(3'd2, 32'd2);
    bus_write(3'd3, 32'd3);
    bus_write(3'd0, 32'h1);
    wait_done(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL midrst_done_wait got=timeout required=done");
    end
    sb_q.push_back(32'd8);
    bus_read(3'd4, rd);
    want = sb_q.pop_front();
    vectors++;
    if (rd !== want) begin
      miscompares++;
      $display("FAIL midrst_result got=%0d required=%0d", rd, want);
    end
    sb_q.push_back(32'd8);
    bus_read(3'd5, rd);
    want = sb_q.pop_front();
    vectors++;
    if (rd !== want) begin
      miscompares++;
      $display("FAIL midrst_cycles got=%0d required=%0d", rd, want);
    end
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    starts        = 0;
    hang          = 1'b0;
    model_rst     = 1'b1;
    reset         = 1'b1;
    bif.address   = 3'd0;
    bif.write     = 1'b0;
    bif.writedata = 32'd0;
    bif.read      = 1'b0;
    @(negedge clock);
    test_reset();
    test_basic();
    test_clear_and_zero_exp();
    test_busy_writes();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
